// File: rtl/mp3_ctrl_pkg.sv
// mp3_ctrl_pkg
// Shared definitions for the playback control path: command op encodings,
// the playback_arbiter FSM state encoding, and the packing of one
// attenuation byte into the decoder's SCI_VOL word (left and right channels).
package mp3_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NEXT      = 3'd0,
    OP_PREV      = 3'd1,
    OP_VOL_UP    = 3'd2,
    OP_VOL_DOWN  = 3'd3,
    OP_SET_TRACK = 3'd4,
    OP_SET_VOL   = 3'd5,
    OP_RSVD6     = 3'd6,
    OP_RSVD7     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_APPLY    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_e;

  // The same attenuation is applied to both channels.
  function automatic logic [15:0] sci_vol(input logic [7:0] att);
    return {att, att};
  endfunction

endpackage

// File: rtl/ctrl_arbiter.sv
// ctrl_arbiter
// Two-way priority pick between the button and Bluetooth command sources.
// The ena-preferred source wins a contention unless the other source lost the
// previous contention, in which case that loser wins once.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   ena             1 = Bluetooth preferred, 0 = buttons preferred
//   btn_valid       button source has a command
//   bt_valid        Bluetooth source has a command
//   idle            arbiter may grant this cycle (FSM in IDLE)
//   grant_btn       one-hot grant to the button source
//   grant_bt        one-hot grant to the Bluetooth source
module ctrl_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_valid,
  input  logic bt_valid,
  input  logic idle,
  output logic grant_btn,
  output logic grant_bt
);

  // have_loser: at least one contention has happened since reset.
  // lost_bt:    the source that lost the most recent contention.
  logic have_loser;
  logic lost_bt;
  logic pick_bt;
  logic contend;

  assign contend = idle & btn_valid & bt_valid;

  // Under contention the previous loser wins; if that loser was the
  // preferred source this is just normal priority, so the non-preferred
  // source only ever gets one win in a row.
  always_comb begin
    pick_bt = bt_valid;
    if (btn_valid && bt_valid) begin
      pick_bt = have_loser ? lost_bt : ena;
    end
  end

  assign grant_bt  = idle & bt_valid & pick_bt;
  assign grant_btn = idle & btn_valid & ~pick_bt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_loser <= 1'b0;
      lost_bt    <= 1'b0;
    end else if (contend) begin
      have_loser <= 1'b1;
      lost_bt    <= ~pick_bt;
    end
  end

endmodule

// File: rtl/playback_arbiter.sv
// playback_arbiter
// Accepts track/volume commands from the button and Bluetooth sources via
// valid/ready, owns the authoritative track index and SCI_VOL word, and
// announces each applied change to the mp3 decoder with a req/ack handshake
// guarded by a timeout.
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   ena                         source priority (1 = Bluetooth preferred)
//   btn_valid/op/arg, btn_ready button command channel
//   bt_valid/op/arg, bt_ready   Bluetooth command channel
//   current                     active track index
//   volume                      SCI_VOL word {att, att}
//   chg_req, chg_track, chg_ack change handshake toward the decoder
//   busy                        FSM not idle
//   err                         sticky ack-timeout flag
module playback_arbiter
  import mp3_ctrl_pkg::*;
#(
  parameter int         NUM_TRACKS  = 8,
  parameter logic [7:0] VOL_STEP    = 8'h10,
  parameter logic [7:0] VOL_DEF_ATT = 8'h20,
  parameter logic [7:0] VOL_MAX_ATT = 8'hF0,
  parameter int         ACK_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        btn_valid,
  input  logic [2:0]  btn_op,
  input  logic [7:0]  btn_arg,
  output logic        btn_ready,
  input  logic        bt_valid,
  input  logic [2:0]  bt_op,
  input  logic [7:0]  bt_arg,
  output logic        bt_ready,
  output logic [2:0]  current,
  output logic [15:0] volume,
  output logic        chg_req,
  output logic        chg_track,
  input  logic        chg_ack,
  output logic        busy,
  output logic        err
);

  localparam int             TW         = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]     LAST_TRACK = 3'(NUM_TRACKS - 1);
  localparam logic [7:0]     NUM_TR_8   = 8'(NUM_TRACKS);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  state_e        state, state_nxt;
  op_e           op_q;
  logic [7:0]    arg_q;
  logic [2:0]    cur_q;
  logic [7:0]    att_q;
  logic          chg_track_q;
  logic          err_q;
  logic [TW-1:0] timer_q;

  logic          grant_btn, grant_bt, take;
  logic [2:0]    track_new;
  logic [7:0]    att_new;
  logic [8:0]    att_sum;
  logic          is_track;
  logic          changed;

  ctrl_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .btn_valid (btn_valid),
    .bt_valid  (bt_valid),
    .idle      (state == S_IDLE),
    .grant_btn (grant_btn),
    .grant_bt  (grant_bt)
  );

  // Grants are only issued to a valid source, so a grant is a transfer.
  assign btn_ready = grant_btn;
  assign bt_ready  = grant_bt;
  assign take      = grant_btn | grant_bt;

  // New-value computation for the latched command (used in APPLY).
  always_comb begin
    track_new = cur_q;
    att_new   = att_q;
    is_track  = 1'b0;
    // 9-bit sum so VOL_DOWN near the top cannot wrap around to loud.
    att_sum   = {1'b0, att_q} + {1'b0, VOL_STEP};
    case (op_q)
      OP_NEXT: begin
        is_track  = 1'b1;
        track_new = (cur_q == LAST_TRACK) ? 3'd0 : cur_q + 3'd1;
      end
      OP_PREV: begin
        is_track  = 1'b1;
        track_new = (cur_q == 3'd0) ? LAST_TRACK : cur_q - 3'd1;
      end
      OP_SET_TRACK: begin
        is_track = 1'b1;
        if (arg_q < NUM_TR_8) track_new = arg_q[2:0];
      end
      OP_VOL_UP:   att_new = (att_q >= VOL_STEP) ? att_q - VOL_STEP : 8'h00;
      OP_VOL_DOWN: att_new = (att_sum > {1'b0, VOL_MAX_ATT}) ? VOL_MAX_ATT : att_sum[7:0];
      OP_SET_VOL:  att_new = (arg_q > VOL_MAX_ATT) ? VOL_MAX_ATT : arg_q;
      default: ;
    endcase
    changed = (track_new != cur_q) || (att_new != att_q);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (take) state_nxt = S_APPLY;
      S_APPLY:    state_nxt = changed ? S_WAIT_ACK : S_IDLE;
      S_WAIT_ACK: if (chg_ack || timer_q == TIMER_LAST) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= OP_NEXT;
      arg_q       <= 8'h00;
      cur_q       <= 3'd0;
      att_q       <= VOL_DEF_ATT;
      chg_track_q <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      // IDLE -> APPLY: capture the granted command
      if (state == S_IDLE && take) begin
        op_q  <= grant_bt ? op_e'(bt_op) : op_e'(btn_op);
        arg_q <= grant_bt ? bt_arg : btn_arg;
      end
      // APPLY -> WAIT_ACK: commit the new value and start the timer
      if (state == S_APPLY && changed) begin
        cur_q       <= track_new;
        att_q       <= att_new;
        chg_track_q <= is_track;
        timer_q     <= '0;
      end
      // WAIT_ACK: count toward timeout; the committed values are kept either way
      if (state == S_WAIT_ACK && !chg_ack) begin
        if (timer_q == TIMER_LAST) err_q   <= 1'b1;
        else                       timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign current   = cur_q;
  assign volume    = sci_vol(att_q);
  assign chg_req   = (state == S_WAIT_ACK);
  assign chg_track = chg_track_q;
  assign busy      = (state != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_playback_arbiter.sv
module tb_playback_arbiter;
  import mp3_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        btn_valid = 1'b0;
  logic [2:0]  btn_op = 3'd0;
  logic [7:0]  btn_arg = 8'h00;
  logic        btn_ready;
  logic        bt_valid = 1'b0;
  logic [2:0]  bt_op = 3'd0;
  logic [7:0]  bt_arg = 8'h00;
  logic        bt_ready;
  logic [2:0]  current;
  logic [15:0] volume;
  logic        chg_req;
  logic        chg_track;
  logic        chg_ack = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  playback_arbiter #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .btn_valid(btn_valid), .btn_op(btn_op), .btn_arg(btn_arg), .btn_ready(btn_ready),
    .bt_valid(bt_valid), .bt_op(bt_op), .bt_arg(bt_arg), .bt_ready(bt_ready),
    .current(current), .volume(volume), .chg_req(chg_req), .chg_track(chg_track),
    .chg_ack(chg_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Present one command at a negedge, record ready, drop valid one cycle later.
  // Returns positioned in the APPLY cycle (T+1).
  task automatic issue(input bit use_bt, input logic [2:0] op, input logic [7:0] arg,
                       output logic got_ready);
    if (use_bt) begin bt_valid = 1'b1; bt_op = op; bt_arg = arg; end
    else begin btn_valid = 1'b1; btn_op = op; btn_arg = arg; end
    #1 got_ready = use_bt ? bt_ready : btn_ready;
    @(negedge clk);
    bt_valid = 1'b0;
    btn_valid = 1'b0;
  endtask

  task automatic ack();
    chg_ack = 1'b1;
    @(negedge clk);
    chg_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (current !== 3'd0) begin errors++; $display("FAIL reset_current got %0d want 0", current); end
    checks++; if (volume !== 16'h2020) begin errors++; $display("FAIL reset_volume got %h want 2020", volume); end
    checks++; if (chg_req !== 1'b0 || chg_track !== 1'b0) begin errors++; $display("FAIL reset_chg got %b%b want 00", chg_req, chg_track); end
    checks++; if (btn_ready !== 1'b0 || bt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", btn_ready, bt_ready); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b want 00", busy, err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_next();
    logic r;
    issue(1'b0, OP_NEXT, 8'h00, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL next_ready got %b want 1", r); end
    checks++; if (btn_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL next_apply ready/busy got %b%b want 01", btn_ready, busy); end
    checks++; if (current !== 3'd0 || chg_req !== 1'b0) begin errors++; $display("FAIL next_early cur/req got %0d/%b want 0/0", current, chg_req); end
    @(negedge clk);
    checks++; if (current !== 3'd1) begin errors++; $display("FAIL next_current got %0d want 1", current); end
    checks++; if (chg_req !== 1'b1 || chg_track !== 1'b1) begin errors++; $display("FAIL next_chg got %b%b want 11", chg_req, chg_track); end
    ack();
    checks++; if (chg_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL next_ack req/busy got %b%b want 00", chg_req, busy); end
  endtask

  task automatic test_priority();
    ena = 1'b1;
    btn_valid = 1'b1; btn_op = OP_VOL_UP; btn_arg = 8'h00;
    bt_valid = 1'b1; bt_op = OP_SET_TRACK; bt_arg = 8'h05;
    #1;
    checks++; if (bt_ready !== 1'b1 || btn_ready !== 1'b0) begin errors++; $display("FAIL prio_ena1 bt/btn ready got %b%b want 10", bt_ready, btn_ready); end
    @(negedge clk);
    bt_valid = 1'b0;
    @(negedge clk);
    checks++; if (current !== 3'd5 || chg_track !== 1'b1) begin errors++; $display("FAIL prio_bt_track got %0d/%b want 5/1", current, chg_track); end
    checks++; if (btn_ready !== 1'b0) begin errors++; $display("FAIL prio_wait_ready got %b want 0", btn_ready); end
    ack();
    checks++; if (btn_ready !== 1'b1) begin errors++; $display("FAIL prio_btn_after got %b want 1", btn_ready); end
    @(negedge clk);
    btn_valid = 1'b0;
    @(negedge clk);
    checks++; if (volume !== 16'h1010 || chg_track !== 1'b0 || chg_req !== 1'b1) begin
      errors++; $display("FAIL prio_btn_vol got %h/%b/%b want 1010/0/1", volume, chg_track, chg_req); end
    ack();
  endtask

  task automatic test_alternate();
    logic        exp_bt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  exp_cur[4] = '{3'd5, 3'd6, 3'd6, 3'd7};
    logic [15:0] exp_vol[4] = '{16'h2020, 16'h2020, 16'h3030, 16'h3030};
    ena = 1'b0;
    btn_valid = 1'b1; btn_op = OP_VOL_DOWN; btn_arg = 8'h00;
    bt_valid = 1'b1; bt_op = OP_NEXT; bt_arg = 8'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bt_ready !== exp_bt[i] || btn_ready !== !exp_bt[i]) begin
        errors++; $display("FAIL alt_grant%0d bt/btn got %b%b want %b%b", i, bt_ready, btn_ready, exp_bt[i], !exp_bt[i]); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (current !== exp_cur[i] || volume !== exp_vol[i]) begin
        errors++; $display("FAIL alt_value%0d got %0d/%h want %0d/%h", i, current, volume, exp_cur[i], exp_vol[i]); end
      chg_ack = 1'b1;
      @(negedge clk);
      chg_ack = 1'b0;
    end
    btn_valid = 1'b0;
    bt_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic r;
    issue(1'b0, OP_NEXT, 8'h00, r);
    @(negedge clk);
    checks++; if (current !== 3'd0 || chg_req !== 1'b1) begin errors++; $display("FAIL wrap_next got %0d/%b want 0/1", current, chg_req); end
    ack();
    issue(1'b1, OP_PREV, 8'h00, r);
    @(negedge clk);
    checks++; if (current !== 3'd7 || chg_track !== 1'b1) begin errors++; $display("FAIL wrap_prev got %0d/%b want 7/1", current, chg_track); end
    ack();
    issue(1'b0, OP_SET_TRACK, 8'h09, r);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL set9_ready got %b want 1", r); end
    @(negedge clk);
    checks++; if (chg_req !== 1'b0 || busy !== 1'b0 || current !== 3'd7) begin
      errors++; $display("FAIL set9_nochange got %b/%b/%0d want 0/0/7", chg_req, busy, current); end
  endtask

  task automatic test_vol_clamp();
    logic r;
    issue(1'b1, OP_SET_VOL, 8'hFF, r);
    @(negedge clk);
    checks++; if (volume !== 16'hF0F0 || chg_req !== 1'b1) begin errors++; $display("FAIL setvol_ff got %h/%b want f0f0/1", volume, chg_req); end
    ack();
    issue(1'b0, OP_VOL_DOWN, 8'h00, r);
    @(negedge clk);
    checks++; if (r !== 1'b1 || chg_req !== 1'b0 || volume !== 16'hF0F0) begin
      errors++; $display("FAIL voldown_clamp got %b/%b/%h want 1/0/f0f0", r, chg_req, volume); end
    issue(1'b0, OP_SET_VOL, 8'h08, r);
    @(negedge clk);
    checks++; if (volume !== 16'h0808) begin errors++; $display("FAIL setvol_08 got %h want 0808", volume); end
    ack();
    issue(1'b1, OP_VOL_UP, 8'h00, r);
    @(negedge clk);
    checks++; if (volume !== 16'h0000 || chg_req !== 1'b1) begin errors++; $display("FAIL volup_floor got %h/%b want 0000/1", volume, chg_req); end
    ack();
  endtask

  task automatic test_timeout();
    logic r;
    int   cnt;
    chg_ack = 1'b1;
    @(negedge clk);
    chg_ack = 1'b0;
    checks++; if (busy !== 1'b0 || chg_req !== 1'b0) begin errors++; $display("FAIL idle_ack got %b/%b want 0/0", busy, chg_req); end
    issue(1'b0, OP_NEXT, 8'h00, r);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (chg_req) cnt++;
      else if (cnt != 0) break;
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL timeout_len got %0d want 16", cnt); end
    checks++; if (err !== 1'b1 || busy !== 1'b0 || current !== 3'd0) begin
      errors++; $display("FAIL timeout_state got %b/%b/%0d want 1/0/0", err, busy, current); end
    issue(1'b1, OP_NEXT, 8'h00, r);
    @(negedge clk);
    ack();
    checks++; if (err !== 1'b1 || current !== 3'd1) begin errors++; $display("FAIL err_sticky got %b/%0d want 1/1", err, current); end
  endtask

  task automatic test_async_reset();
    logic r;
    issue(1'b0, OP_NEXT, 8'h00, r);
    @(negedge clk);
    checks++; if (chg_req !== 1'b1 || current !== 3'd2) begin errors++; $display("FAIL pre_reset got %b/%0d want 1/2", chg_req, current); end
    #2 rst = 1'b0;
    #1;
    checks++; if (chg_req !== 1'b0 || current !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got %b/%0d/%b want 0/0/0", chg_req, current, busy); end
    checks++; if (volume !== 16'h2020 || err !== 1'b0) begin errors++; $display("FAIL async_reset_vol got %h/%b want 2020/0", volume, err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_next();
    test_priority();
    test_alternate();
    test_wrap();
    test_vol_clamp();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
